// File: rtl/serial_adder_nbit_if.sv
// Handshake and operand/result bus for serial_adder_nbit.
// The master issues start with operands; the slave reports busy/done and holds the result.
interface serial_adder_nbit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             car;
    logic             ovf;

    modport master (
        output start, a, b, c, sub,
        input  busy, done, s, car, ovf
    );

    modport slave (
        input  start, a, b, c, sub,
        output busy, done, s, car, ovf
    );
endinterface

// File: rtl/serial_adder_nbit.sv
// Multi-cycle add/subtract: BITS_PER_CYCLE full-adder slices per clock, with the
// carry registered between cycles; start/busy/done handshake.
module serial_adder_nbit_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_nbit #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_nbit_if.slave   bus
);
    localparam int BPC = BITS_PER_CYCLE;
    localparam int N   = WIDTH / BPC;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int RW  = (N > 1) ? WIDTH - BPC : 1;

    if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
        $error("serial_adder_nbit: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b;
    logic [RW-1:0]    r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_car, r_ovf;

    logic [BPC:0]     w_cy;
    logic [BPC-1:0]   w_sum;
    logic [WIDTH-1:0] w_res_next;
    logic             w_accept, w_last;

    assign w_cy[0] = r_carry;

    for (genvar i = 0; i < BPC; i++) begin : g_slice
        serial_adder_nbit_fa u_fa (
            .i_a (r_a[i]),
            .i_b (r_b[i]),
            .i_c (w_cy[i]),
            .o_s (w_sum[i]),
            .o_c (w_cy[i+1])
        );
    end

    // New slice enters at the top; after N shifts the LSB slice has reached bit 0.
    if (N > 1) begin : g_multi
        assign w_res_next = {w_sum, r_res};
    end else begin : g_single
        assign w_res_next = w_sum;
    end

    assign w_accept = bus.start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_cnt == CW'(N - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    w_next = bus.start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_car   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtract is A + ~B + ~borrow, so the same adder serves both.
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.c ^ bus.sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> BPC;
            r_b     <= r_b >> BPC;
            r_res   <= w_res_next[WIDTH-1 -: RW];
            r_carry <= w_cy[BPC];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_s   <= w_res_next;
                r_car <= w_cy[BPC];
                r_ovf <= w_cy[BPC] ^ w_cy[BPC-1];
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.s    = r_s;
    assign bus.car  = r_car;
    assign bus.ovf  = r_ovf;
endmodule
